issue_scoreboard: RTL and testbench
===================================

// Module: issue_scoreboard
// PURPOSE
// - Issue controller between instr_decode and the execute units.
// - Tracks destination registers with in-flight writes from multi-cycle units (LOAD, MUL, DIV).
// - Detects RAW/WAW/structural hazards on the decode-stage instruction and drives the decode stall.
// - Sequences the non-pipelined divider (one op in flight) and caps outstanding LSU ops.
// PARAMETERS
// - NumRegs   32  architectural integer registers tracked
// - RegWidth  5   register address width, = $clog2(NumRegs)
// - MaxLsuOps 2   max LOAD/STORE ops issued but not yet completed (>=1)
// PORTS
// - clk_i               in   1               clock
// - rst_ni              in   1               reset, asynchronous, active-low
// - issue_valid_i       in   1               decode holds a valid instruction
// - issue_unit_i        in   issue_unit_t    target unit: ALU/LOAD/STORE/MUL/DIV/CSR
// - issue_raddr_i       in   2xRegWidth      rs1/rs2 addresses
// - issue_rsel_i        in   2               rs1/rs2 actually read
// - issue_waddr_i       in   RegWidth        rd address
// - flush_i             in   1               pipeline flush; blocks issue this cycle
// - lsu_wb_valid_i      in   1               LSU load result written back
// - lsu_wb_waddr_i      in   RegWidth        rd of that load
// - lsu_done_i          in   1               LSU op (load or store) retired from LSU
// - mul_wb_valid_i      in   1               MUL result written back
// - mul_wb_waddr_i      in   RegWidth        rd of that MUL
// - div_wb_valid_i      in   1               DIV result written back (divider free)
// - div_wb_waddr_i      in   RegWidth        rd of that DIV
// - decode_stall_o      out  1               hazard: hold decode (feeds decode_stall_i)
// - issue_fire_o        out  1               instruction issues this cycle
// - pending_o           out  NumRegs         registered pending-write bitmap
// - div_busy_o          out  1               divider FSM in BUSY
// - lsu_count_o         out  $clog2(MaxLsuOps+1)  outstanding LSU ops
// BEHAVIOUR
// - Reset (async, rst_ni=0): pending=0, div FSM IDLE, lsu_count=0; decode_stall_o=0 and issue_fire_o=0 while issue_valid_i=0.
// - clr[r] = same-cycle writeback of r on any wb port; eff_pend = pending_q & ~clr (same-cycle clears are visible, zero-bubble).
// - raw = for i in 0..1: issue_rsel_i[i] & eff_pend[issue_raddr_i[i]].
// - waw = writes_rd & eff_pend[issue_waddr_i]; writes_rd = unit in {ALU,LOAD,MUL,DIV,CSR} & rd!=0.
// - struct = (unit==DIV & div_busy & ~div_wb_valid_i) | (unit in {LOAD,STORE} & lsu_count==MaxLsuOps & ~lsu_done_i).
// - decode_stall_o = issue_valid_i & (raw|waw|struct); combinational, no flop on the path.
// - issue_fire_o = issue_valid_i & ~decode_stall_o & ~flush_i.
// - Set: on fire, unit in {LOAD,MUL,DIV} and rd!=0 -> pending[rd]<=1 next edge. ALU/CSR never set pending (1-cycle, forwarded).
// - Same edge: the set wins over a clear of the same rd; clears of other regs apply normally.
// - x0: pending[0] is constant 0 and never reported as a hazard.
// - Div FSM: IDLE->BUSY on fire of DIV; BUSY->IDLE on div_wb_valid_i; fire of DIV while div_wb_valid_i in BUSY -> stays BUSY.
// - div_wb_valid_i in IDLE: ignored (assertion error).
// - LSU counter: +1 on fire of LOAD/STORE, -1 on lsu_done_i; both in one cycle -> hold.
// - lsu_done_i at 0 is ignored (assertion); counter never exceeds MaxLsuOps.
// - Flush: blocks fire only; pending bits, the div FSM and the LSU count are kept, because in-flight ops still write back and clear them.
// - Wb for a reg not pending: no-op (assertion warning).
// - Reset mid-operation: all state cleared immediately; late wb pulses after reset are treated as stray (no-op).
// STRUCTURE
// - riscv_pkg: issue_unit_t enum {IU_ALU, IU_LOAD, IU_STORE, IU_MUL, IU_DIV, IU_CSR}.
// - riscv_pkg: DIV FSM state typedef div_state_t {DIV_IDLE, DIV_BUSY}.
// - Sub-module lsu_credit_counter: up/down saturating counter with full flag, params Max.
// - Pending bitmap, hazard logic and div FSM stay in this module.
// TESTING
// - LOAD x5 fires, next cycle ADD x6,x5,x1 -> stall=1 until lsu_wb(x5); same-cycle issue then fires with stall=0.
// - DIV x3 fires; DIV x4 next cycle -> stall (struct); div_wb(x3) -> second DIV fires that cycle; div_busy_o stays 1.
// - 3 stores back-to-back, MaxLsuOps=2, no done -> third stalls, lsu_count_o=2; one lsu_done_i -> third fires, count stays 2.
// - MUL x0 fires -> pending_o stays 0; following ADD x1,x0,x0 issues with no stall.
// - MUL x7 in flight; flush_i with MUL x7 in decode -> no fire; mul_wb(x7) clears pending[7]; div FSM/count unchanged.
// - rst_ni low with pending=0x20, div BUSY, count=1 -> all zero, IDLE asynchronously; fire resumes after release.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared types for the issue stage: target execute units, divider FSM states
// and small unit-classification helpers used by the scoreboard.
package riscv_pkg;

    typedef enum logic [2:0] {
        IU_ALU,
        IU_LOAD,
        IU_STORE,
        IU_MUL,
        IU_DIV,
        IU_CSR
    } issue_unit_t;

    typedef enum logic {
        DIV_IDLE,
        DIV_BUSY
    } div_state_t;

    // Units that produce a register result (STORE has no destination).
    function automatic logic unit_writes_rd(input issue_unit_t unit);
        return (unit != IU_STORE);
    endfunction

    // Multi-cycle producers; ALU/CSR results are forwarded and never tracked.
    function automatic logic unit_sets_pending(input issue_unit_t unit);
        return (unit == IU_LOAD) || (unit == IU_MUL) || (unit == IU_DIV);
    endfunction

    function automatic logic unit_is_lsu(input issue_unit_t unit);
        return (unit == IU_LOAD) || (unit == IU_STORE);
    endfunction

endpackage

// File: rtl/lsu_credit_counter.sv
// Up/down counter of outstanding LSU operations, saturating at Max, with a
// full flag used by the issue logic as a structural hazard.
module lsu_credit_counter #(
    parameter int Max  = 2,
    parameter int CntW = $clog2(Max + 1)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            inc_i,
    input  logic            dec_i,
    output logic [CntW-1:0] count_o,
    output logic            full_o
);

    logic [CntW-1:0] count_q;
    logic            dec_ok;

    // A retire with nothing outstanding is stray and must not wrap the count.
    assign dec_ok = dec_i && (count_q != '0);
    assign full_o = (count_q == CntW'(Max));
    assign count_o = count_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else if (inc_i && !dec_ok && !full_o) begin
            count_q <= count_q + CntW'(1);
        end else if (dec_ok && !inc_i) begin
            count_q <= count_q - CntW'(1);
        end
    end

endmodule

// File: rtl/issue_scoreboard.sv
// Issue scoreboard: tracks in-flight register writes from multi-cycle units,
// detects RAW/WAW/structural hazards and sequences the single-op divider.
module issue_scoreboard
    import riscv_pkg::*;
#(
    parameter int NumRegs   = 32,
    parameter int RegWidth  = $clog2(NumRegs),
    parameter int MaxLsuOps = 2,
    parameter int LsuCntW   = $clog2(MaxLsuOps + 1)
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     issue_valid_i,
    input  issue_unit_t              issue_unit_i,
    input  logic [1:0][RegWidth-1:0] issue_raddr_i,
    input  logic [1:0]               issue_rsel_i,
    input  logic [RegWidth-1:0]      issue_waddr_i,
    input  logic                     flush_i,
    input  logic                     lsu_wb_valid_i,
    input  logic [RegWidth-1:0]      lsu_wb_waddr_i,
    input  logic                     lsu_done_i,
    input  logic                     mul_wb_valid_i,
    input  logic [RegWidth-1:0]      mul_wb_waddr_i,
    input  logic                     div_wb_valid_i,
    input  logic [RegWidth-1:0]      div_wb_waddr_i,
    output logic                     decode_stall_o,
    output logic                     issue_fire_o,
    output logic [NumRegs-1:0]       pending_o,
    output logic                     div_busy_o,
    output logic [LsuCntW-1:0]       lsu_count_o
);

    logic [NumRegs-1:0] pending_q, pending_d;
    logic [NumRegs-1:0] clr, eff_pend;
    logic               raw_hazard, waw_hazard, struct_hazard;
    logic               writes_rd, is_div, is_lsu, lsu_full;
    logic               div_wb_ok;
    div_state_t         div_state_q, div_state_d;

    assign is_div     = (issue_unit_i == IU_DIV);
    assign is_lsu     = unit_is_lsu(issue_unit_i);
    assign writes_rd  = unit_writes_rd(issue_unit_i) && (issue_waddr_i != '0);
    assign div_busy_o = (div_state_q == DIV_BUSY);
    assign div_wb_ok  = div_wb_valid_i && div_busy_o;

    // Writebacks landing this cycle are visible to the decode instruction.
    always_comb begin
        clr = '0;
        if (lsu_wb_valid_i) clr[lsu_wb_waddr_i] = 1'b1;
        if (mul_wb_valid_i) clr[mul_wb_waddr_i] = 1'b1;
        if (div_wb_ok)      clr[div_wb_waddr_i] = 1'b1;
    end

    assign eff_pend = pending_q & ~clr;

    always_comb begin
        raw_hazard = 1'b0;
        for (int i = 0; i < 2; i++) begin
            if (issue_rsel_i[i] && eff_pend[issue_raddr_i[i]]) raw_hazard = 1'b1;
        end
    end

    assign waw_hazard    = writes_rd && eff_pend[issue_waddr_i];
    assign struct_hazard = (is_div && div_busy_o && !div_wb_valid_i)
                         || (is_lsu && lsu_full && !lsu_done_i);

    assign decode_stall_o = issue_valid_i && (raw_hazard || waw_hazard || struct_hazard);
    assign issue_fire_o   = issue_valid_i && !decode_stall_o && !flush_i;

    // The set is applied after the clears so a same-edge set of rd wins.
    always_comb begin
        pending_d = eff_pend;
        if (issue_fire_o && unit_sets_pending(issue_unit_i) && (issue_waddr_i != '0)) begin
            pending_d[issue_waddr_i] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    assign pending_o = pending_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            div_state_q <= DIV_IDLE;
        end else begin
            div_state_q <= div_state_d;
        end
    end

    always_comb begin
        div_state_d = div_state_q;
        case (div_state_q)
            DIV_IDLE: if (issue_fire_o && is_div) div_state_d = DIV_BUSY;
            DIV_BUSY: if (div_wb_valid_i && !(issue_fire_o && is_div)) div_state_d = DIV_IDLE;
            default:  div_state_d = DIV_IDLE;
        endcase
    end

    lsu_credit_counter #(
        .Max  (MaxLsuOps),
        .CntW (LsuCntW)
    ) u_lsu_credit (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .inc_i   (issue_fire_o && is_lsu),
        .dec_i   (lsu_done_i),
        .count_o (lsu_count_o),
        .full_o  (lsu_full)
    );

    // Protocol checks on the writeback/retire interfaces.
    always @(posedge clk_i) begin
        if (rst_ni) begin
            assert (!(div_wb_valid_i && !div_busy_o))
                else $error("issue_scoreboard: div writeback while divider idle");
            assert (!(lsu_done_i && lsu_count_o == '0))
                else $error("issue_scoreboard: lsu_done with no outstanding op");
            if (lsu_wb_valid_i) assert (pending_q[lsu_wb_waddr_i])
                else $warning("issue_scoreboard: lsu writeback to non-pending reg");
            if (mul_wb_valid_i) assert (pending_q[mul_wb_waddr_i])
                else $warning("issue_scoreboard: mul writeback to non-pending reg");
            if (div_wb_valid_i) assert (pending_q[div_wb_waddr_i] || div_wb_waddr_i == '0)
                else $warning("issue_scoreboard: div writeback to non-pending reg");
        end
    end

endmodule

// File: tb/tb_issue_scoreboard.sv
// Table-driven bench for issue_scoreboard: combinational stall/fire checked
// before each edge, post-edge state checked through a scoreboard queue.
module tb_issue_scoreboard;
    import riscv_pkg::*;

    logic              clk_i = 1'b0;
    logic              rst_ni = 1'b0;
    logic              issue_valid_i = 1'b0;
    issue_unit_t       issue_unit_i = IU_ALU;
    logic [1:0][4:0]   issue_raddr_i = '0;
    logic [1:0]        issue_rsel_i = '0;
    logic [4:0]        issue_waddr_i = '0;
    logic              flush_i = 1'b0;
    logic              lsu_wb_valid_i = 1'b0;
    logic [4:0]        lsu_wb_waddr_i = '0;
    logic              lsu_done_i = 1'b0;
    logic              mul_wb_valid_i = 1'b0;
    logic [4:0]        mul_wb_waddr_i = '0;
    logic              div_wb_valid_i = 1'b0;
    logic [4:0]        div_wb_waddr_i = '0;
    logic              decode_stall_o;
    logic              issue_fire_o;
    logic [31:0]       pending_o;
    logic              div_busy_o;
    logic [1:0]        lsu_count_o;

    issue_scoreboard dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .issue_valid_i  (issue_valid_i),
        .issue_unit_i   (issue_unit_i),
        .issue_raddr_i  (issue_raddr_i),
        .issue_rsel_i   (issue_rsel_i),
        .issue_waddr_i  (issue_waddr_i),
        .flush_i        (flush_i),
        .lsu_wb_valid_i (lsu_wb_valid_i),
        .lsu_wb_waddr_i (lsu_wb_waddr_i),
        .lsu_done_i     (lsu_done_i),
        .mul_wb_valid_i (mul_wb_valid_i),
        .mul_wb_waddr_i (mul_wb_waddr_i),
        .div_wb_valid_i (div_wb_valid_i),
        .div_wb_waddr_i (div_wb_waddr_i),
        .decode_stall_o (decode_stall_o),
        .issue_fire_o   (issue_fire_o),
        .pending_o      (pending_o),
        .div_busy_o     (div_busy_o),
        .lsu_count_o    (lsu_count_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        string       name;
        logic        valid;
        issue_unit_t unit;
        logic [4:0]  rs1, rs2;
        logic [1:0]  rsel;
        logic [4:0]  rd;
        logic        flush;
        logic        lwb;
        logic [4:0]  lwa;
        logic        ldone;
        logic        mwb;
        logic [4:0]  mwa;
        logic        dwb;
        logic [4:0]  dwa;
        logic        exp_stall, exp_fire;
        logic [31:0] exp_pend;
        logic        exp_busy;
        logic [1:0]  exp_cnt;
    } vec_t;

    typedef struct {
        string       name;
        logic [31:0] pend;
        logic        busy;
        logic [1:0]  cnt;
    } exp_state_t;

    vec_t       vectors[$];
    exp_state_t expected_q[$];
    int         applied = 0;
    int         checks = 0;
    int         miscompares = 0;

    function automatic vec_t mk(string name, logic v, issue_unit_t u, logic [4:0] rs1, logic [4:0] rs2,
                                logic [1:0] rsel, logic [4:0] rd, logic fl, logic lwb, logic [4:0] lwa,
                                logic ldone, logic mwb, logic [4:0] mwa, logic dwb, logic [4:0] dwa,
                                logic st, logic fi, logic [31:0] pend, logic busy, logic [1:0] cnt);
        vec_t r;
        r.name = name; r.valid = v; r.unit = u; r.rs1 = rs1; r.rs2 = rs2; r.rsel = rsel; r.rd = rd;
        r.flush = fl; r.lwb = lwb; r.lwa = lwa; r.ldone = ldone; r.mwb = mwb; r.mwa = mwa;
        r.dwb = dwb; r.dwa = dwa; r.exp_stall = st; r.exp_fire = fi; r.exp_pend = pend;
        r.exp_busy = busy; r.exp_cnt = cnt;
        return r;
    endfunction

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic apply_stimulus(input vec_t v);
        exp_state_t e;
        @(negedge clk_i);
        issue_valid_i    = v.valid;
        issue_unit_i     = v.unit;
        issue_raddr_i[0] = v.rs1;
        issue_raddr_i[1] = v.rs2;
        issue_rsel_i     = v.rsel;
        issue_waddr_i    = v.rd;
        flush_i          = v.flush;
        lsu_wb_valid_i   = v.lwb;
        lsu_wb_waddr_i   = v.lwa;
        lsu_done_i       = v.ldone;
        mul_wb_valid_i   = v.mwb;
        mul_wb_waddr_i   = v.mwa;
        div_wb_valid_i   = v.dwb;
        div_wb_waddr_i   = v.dwa;
        #1;
        check_output({v.name, ".stall"}, 32'(decode_stall_o), 32'(v.exp_stall));
        check_output({v.name, ".fire"}, 32'(issue_fire_o), 32'(v.exp_fire));
        e.name = v.name; e.pend = v.exp_pend; e.busy = v.exp_busy; e.cnt = v.exp_cnt;
        expected_q.push_back(e);
        applied++;
        @(posedge clk_i);
        #1;
        if (expected_q.size() == 0) begin
            check_output("scoreboard_underflow", 32'd1, 32'd0);
        end else begin
            e = expected_q.pop_front();
            check_output({e.name, ".pending"}, pending_o, e.pend);
            check_output({e.name, ".div_busy"}, 32'(div_busy_o), 32'(e.busy));
            check_output({e.name, ".lsu_count"}, 32'(lsu_count_o), 32'(e.cnt));
        end
    endtask

    task automatic idle_inputs();
        issue_valid_i = 1'b0; flush_i = 1'b0; lsu_wb_valid_i = 1'b0; lsu_done_i = 1'b0;
        mul_wb_valid_i = 1'b0; div_wb_valid_i = 1'b0; issue_rsel_i = '0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        //                name                 v  unit      rs1 rs2 rsel   rd  fl lwb lwa ld mwb mwa dwb dwa st fi pend        busy cnt
        vectors.push_back(mk("load_x5",          1, IU_LOAD,  1,  0, 2'b01, 5,  0, 0,  0,  0, 0,  0,  0,  0,  0, 1, 32'h20,     0, 2'd1));
        vectors.push_back(mk("add_rs2_unread",   1, IU_ALU,   1,  5, 2'b01, 6,  0, 0,  0,  0, 0,  0,  0,  0,  0, 1, 32'h20,     0, 2'd1));
        vectors.push_back(mk("add_raw_rs2",      1, IU_ALU,   1,  5, 2'b10, 6,  0, 0,  0,  0, 0,  0,  0,  0,  1, 0, 32'h20,     0, 2'd1));
        vectors.push_back(mk("add_raw_rs1",      1, IU_ALU,   5,  1, 2'b11, 6,  0, 0,  0,  0, 0,  0,  0,  0,  1, 0, 32'h20,     0, 2'd1));
        vectors.push_back(mk("add_on_lsu_wb",    1, IU_ALU,   5,  1, 2'b11, 6,  0, 1,  5,  1, 0,  0,  0,  0,  0, 1, 32'h0,      0, 2'd0));
        vectors.push_back(mk("div_x3",           1, IU_DIV,   1,  2, 2'b11, 3,  0, 0,  0,  0, 0,  0,  0,  0,  0, 1, 32'h08,     1, 2'd0));
        vectors.push_back(mk("div_x4_struct",    1, IU_DIV,   1,  2, 2'b11, 4,  0, 0,  0,  0, 0,  0,  0,  0,  1, 0, 32'h08,     1, 2'd0));
        vectors.push_back(mk("div_x4_on_wb",     1, IU_DIV,   1,  2, 2'b11, 4,  0, 0,  0,  0, 0,  0,  1,  3,  0, 1, 32'h10,     1, 2'd0));
        vectors.push_back(mk("div_x4_wb",        0, IU_ALU,   0,  0, 2'b00, 0,  0, 0,  0,  0, 0,  0,  1,  4,  0, 0, 32'h0,      0, 2'd0));
        vectors.push_back(mk("store_1",          1, IU_STORE, 2,  1, 2'b11, 9,  0, 0,  0,  0, 0,  0,  0,  0,  0, 1, 32'h0,      0, 2'd1));
        vectors.push_back(mk("store_2",          1, IU_STORE, 2,  1, 2'b11, 9,  0, 0,  0,  0, 0,  0,  0,  0,  0, 1, 32'h0,      0, 2'd2));
        vectors.push_back(mk("store_3_full",     1, IU_STORE, 2,  1, 2'b11, 9,  0, 0,  0,  0, 0,  0,  0,  0,  1, 0, 32'h0,      0, 2'd2));
        vectors.push_back(mk("store_3_on_done",  1, IU_STORE, 2,  1, 2'b11, 9,  0, 0,  0,  1, 0,  0,  0,  0,  0, 1, 32'h0,      0, 2'd2));
        vectors.push_back(mk("lsu_drain_1",      0, IU_ALU,   0,  0, 2'b00, 0,  0, 0,  0,  1, 0,  0,  0,  0,  0, 0, 32'h0,      0, 2'd1));
        vectors.push_back(mk("lsu_drain_2",      0, IU_ALU,   0,  0, 2'b00, 0,  0, 0,  0,  1, 0,  0,  0,  0,  0, 0, 32'h0,      0, 2'd0));
        vectors.push_back(mk("mul_x0",           1, IU_MUL,   1,  2, 2'b11, 0,  0, 0,  0,  0, 0,  0,  0,  0,  0, 1, 32'h0,      0, 2'd0));
        vectors.push_back(mk("add_x1_x0_x0",     1, IU_ALU,   0,  0, 2'b11, 1,  0, 0,  0,  0, 0,  0,  0,  0,  0, 1, 32'h0,      0, 2'd0));
        vectors.push_back(mk("mul_x7",           1, IU_MUL,   1,  2, 2'b11, 7,  0, 0,  0,  0, 0,  0,  0,  0,  0, 1, 32'h80,     0, 2'd0));
        vectors.push_back(mk("load_x5_b",        1, IU_LOAD,  1,  0, 2'b01, 5,  0, 0,  0,  0, 0,  0,  0,  0,  0, 1, 32'hA0,     0, 2'd1));
        vectors.push_back(mk("div_x3_b",         1, IU_DIV,   1,  2, 2'b11, 3,  0, 0,  0,  0, 0,  0,  0,  0,  0, 1, 32'hA8,     1, 2'd1));
        vectors.push_back(mk("flush_mul_x7",     1, IU_MUL,   1,  2, 2'b11, 7,  1, 0,  0,  0, 1,  7,  0,  0,  0, 0, 32'h28,     1, 2'd1));
        vectors.push_back(mk("flush_alu",        1, IU_ALU,   1,  2, 2'b11, 10, 1, 0,  0,  0, 0,  0,  0,  0,  0, 0, 32'h28,     1, 2'd1));
        vectors.push_back(mk("alu_waw_x5",       1, IU_ALU,   0,  0, 2'b00, 5,  0, 0,  0,  0, 0,  0,  0,  0,  1, 0, 32'h28,     1, 2'd1));
        vectors.push_back(mk("alu_rsel_off",     1, IU_ALU,   5,  3, 2'b00, 11, 0, 0,  0,  0, 0,  0,  0,  0,  0, 1, 32'h28,     1, 2'd1));
        vectors.push_back(mk("load_x5_set_wins", 1, IU_LOAD,  1,  0, 2'b01, 5,  0, 1,  5,  1, 0,  0,  0,  0,  0, 1, 32'h28,     1, 2'd1));
        vectors.push_back(mk("div_wb_x3",        0, IU_ALU,   0,  0, 2'b00, 0,  0, 0,  0,  0, 0,  0,  1,  3,  0, 0, 32'h20,     0, 2'd1));
        vectors.push_back(mk("div_x0",           1, IU_DIV,   1,  2, 2'b11, 0,  0, 0,  0,  0, 0,  0,  0,  0,  0, 1, 32'h20,     1, 2'd1));
        vectors.push_back(mk("post_rst_load_x5", 1, IU_LOAD,  1,  0, 2'b01, 5,  0, 0,  0,  0, 0,  0,  0,  0,  0, 1, 32'h20,     0, 2'd1));
        vectors.push_back(mk("post_rst_raw",     1, IU_ALU,   5,  0, 2'b01, 6,  0, 0,  0,  0, 0,  0,  0,  0,  1, 0, 32'h20,     0, 2'd1));
        vectors.push_back(mk("post_rst_drain",   0, IU_ALU,   0,  0, 2'b00, 0,  0, 1,  5,  1, 0,  0,  0,  0,  0, 0, 32'h0,      0, 2'd0));

        // Power-on reset state.
        #12;
        check_output("reset.pending", pending_o, 32'h0);
        check_output("reset.div_busy", 32'(div_busy_o), 32'h0);
        check_output("reset.lsu_count", 32'(lsu_count_o), 32'h0);
        check_output("reset.stall", 32'(decode_stall_o), 32'h0);
        check_output("reset.fire", 32'(issue_fire_o), 32'h0);
        @(negedge clk_i);
        rst_ni = 1'b1;

        for (int i = 0; i < 27; i++) apply_stimulus(vectors[i]);

        // Reset asserted mid-cycle with pending=0x20, divider busy, one LSU op out.
        @(negedge clk_i);
        idle_inputs();
        #2;
        rst_ni = 1'b0;
        #1;
        check_output("async_rst.pending", pending_o, 32'h0);
        check_output("async_rst.div_busy", 32'(div_busy_o), 32'h0);
        check_output("async_rst.lsu_count", 32'(lsu_count_o), 32'h0);
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;

        for (int i = 27; i < vectors.size(); i++) apply_stimulus(vectors[i]);

        @(negedge clk_i);
        idle_inputs();
        check_output("scoreboard_drained", 32'(expected_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule
